// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one data-memory port between the instruction-fetch (IF) requester
// and the load/store (LS) requester. One access is granted at a time. The
// memory address, write data and write enable come from registers. The
// arbiter counts the fixed memory latency and then returns the read data
// together with a one-cycle valid pulse. LS has priority over IF. If LS wins
// STARVE_MAX grants in a row while IF is waiting, the next grant is forced
// to IF.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   if_req_i / if_addr_i     IF read request and address
//   if_gnt_o                 IF request accepted this cycle
//   if_rvalid_o / if_rdata_o IF completion pulse and read data
//   ls_req_i / ls_we_i       LS request and write enable
//                            (00 read, 01 byte, 10 half, 11 word)
//   ls_addr_i / ls_wdata_i   LS address and write data
//   ls_gnt_o                 LS request accepted this cycle
//   ls_rvalid_o / ls_rdata_o LS completion pulse and read data (0 for writes)
//   mem_addr_o / mem_wd_o    registered memory address and write data
//   mem_we_o                 memory write enable, asserted for one cycle only
//   mem_rd_i                 memory read data, combinational from mem_addr_o
//   busy_o                   high while an access is in flight
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ls_req_i,
    input  logic [1:0]            ls_we_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [1:0]            mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    output logic                  busy_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [1:0]    CNT_LAST   = 2'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ACC_IF,
        ACC_LS
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              cnt;
    logic [1:0]              cnt_next;
    logic [SW-1:0]           starve;
    logic                    ls_write_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic [DATA_WIDTH-1:0]   ls_rdata_q;

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Grants are combinational and are only issued in IDLE. LS wins unless
    // IF has already been bypassed STARVE_MAX times. The completion pulse is
    // raised in the last access cycle and is held off while reset is asserted,
    // so an aborted access never reports completion.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    ls_gnt_o = ls_req_i && !(if_req_i && (starve == STARVE_TOP));
                    if_gnt_o = if_req_i && !ls_gnt_o;
                end
                if (ls_gnt_o) begin
                    state_next = ACC_LS;
                    cnt_next   = 2'd0;
                end else if (if_gnt_o) begin
                    state_next = ACC_IF;
                    cnt_next   = 2'd0;
                end
            end
            ACC_IF: begin
                cnt_next = cnt + 2'd1;
                if (cnt == CNT_LAST) begin
                    if_rvalid_o = !rst;
                    state_next  = IDLE;
                    cnt_next    = 2'd0;
                end
            end
            ACC_LS: begin
                cnt_next = cnt + 2'd1;
                if (cnt == CNT_LAST) begin
                    ls_rvalid_o = !rst;
                    state_next  = IDLE;
                    cnt_next    = 2'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // Memory-side registers. The write enable is loaded only on an LS grant,
    // so it is asserted for exactly the first access cycle and cleared on
    // every other edge. An IF grant leaves the write data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_o <= '0;
            mem_wd_o   <= '0;
            mem_we_o   <= 2'b00;
            ls_write_q <= 1'b0;
        end else if (ls_gnt_o) begin
            mem_addr_o <= ls_addr_i;
            mem_wd_o   <= ls_wdata_i;
            mem_we_o   <= ls_we_i;
            ls_write_q <= (ls_we_i != 2'b00);
        end else if (if_gnt_o) begin
            mem_addr_o <= if_addr_i;
            mem_we_o   <= 2'b00;
        end else begin
            mem_we_o   <= 2'b00;
        end
    end

    // Starvation counter. It is updated only in IDLE and counts LS grants
    // that bypassed a waiting IF request. It saturates at STARVE_MAX and
    // clears when IF is served or stops asking.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (ls_gnt_o && if_req_i) begin
                if (starve != STARVE_TOP) begin
                    starve <= starve + SW'(1);
                end
            end else if (if_gnt_o || !if_req_i) begin
                starve <= '0;
            end
        end
    end

    // Read-data holding registers. They capture the value presented on the
    // completion cycle so the outputs keep it until the next completion for
    // the same requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (if_rvalid_o) begin
                if_rdata_q <= if_rdata_o;
            end
            if (ls_rvalid_o) begin
                ls_rdata_q <= ls_rdata_o;
            end
        end
    end

    // On the completion cycle the read data comes straight from the memory,
    // because it must be valid together with the pulse. An LS write reports 0.
    assign if_rdata_o = if_rvalid_o ? mem_rd_i : if_rdata_q;
    assign ls_rdata_o = ls_rvalid_o ? (ls_write_q ? '0 : mem_rd_i) : ls_rdata_q;
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomised bench for mem_port_arbiter. The memory is modelled as a fixed
// hash of the address. A reference model tracks when the port is free and
// how many times a waiting IF request has been bypassed, and predicts every
// grant from that. Each accepted request pushes its expected completion
// (cycle and data) into a per-requester queue. An independent monitor pops
// the queue whenever a completion is due and checks the pulse and the data.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [DW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic [1:0]    ls_we = 2'b00;
    logic [DW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [1:0]    mem_we;
    logic [DW-1:0] mem_rd;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Reference model state.
    int          next_free  = 0;
    int          last_grant = -100;
    int          if_bypass  = 0;
    logic [31:0] model_wd   = '0;
    logic [31:0] last_if    = '0;
    logic [31:0] last_ls    = '0;
    bit          mon_en     = 1'b0;
    exp_t        if_q[$];
    exp_t        ls_q[$];
    logic [1:0]  exp_we[int];
    logic [31:0] exp_addr[int];
    logic [31:0] exp_wd[int];

    // Random requester state.
    logic        if_pend = 1'b0;
    logic        ls_pend = 1'b0;
    logic [31:0] if_a = '0;
    logic [31:0] ls_a = '0;
    logic [31:0] ls_d = '0;
    logic [1:0]  ls_w = 2'b00;

    mem_port_arbiter #(
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rvalid_o(if_rvalid),
        .if_rdata_o (if_rdata),
        .ls_req_i   (ls_req),
        .ls_we_i    (ls_we),
        .ls_addr_i  (ls_addr),
        .ls_wdata_i (ls_wdata),
        .ls_gnt_o   (ls_gnt),
        .ls_rvalid_o(ls_rvalid),
        .ls_rdata_o (ls_rdata),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_we_o   (mem_we),
        .mem_rd_i   (mem_rd),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_rd = memf(mem_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Drives one cycle of inputs and checks the grants against the model.
    // When the model predicts a grant, it records everything that grant
    // implies for later cycles.
    task automatic applyStimulus(input logic r, input logic ifr, input logic [31:0] ia,
                                 input logic lsr, input logic [1:0] lw, input logic [31:0] la,
                                 input logic [31:0] lwd, output logic if_acc, output logic ls_acc);
        int   n;
        logic e_if;
        logic e_ls;
        exp_t e;
        @(negedge clk);
        rst      = r;
        if_req   = ifr;
        if_addr  = ia;
        ls_req   = lsr;
        ls_we    = lw;
        ls_addr  = la;
        ls_wdata = lwd;
        #1;
        n    = cycle;
        e_if = 1'b0;
        e_ls = 1'b0;
        if (!r && n >= next_free) begin
            e_ls = lsr && !(ifr && if_bypass >= SMAX);
            e_if = ifr && !e_ls;
            if (e_ls && ifr) begin
                if_bypass = (if_bypass < SMAX) ? if_bypass + 1 : SMAX;
            end else if (e_if || !ifr) begin
                if_bypass = 0;
            end
        end
        checkOutput("ls_gnt", {31'd0, ls_gnt}, {31'd0, e_ls});
        checkOutput("if_gnt", {31'd0, if_gnt}, {31'd0, e_if});
        checkOutput("gnt_exclusive", {31'd0, if_gnt & ls_gnt}, 32'd0);
        if (e_ls) begin
            e.due  = n + LAT;
            e.data = (lw == 2'b00) ? memf(la) : 32'd0;
            ls_q.push_back(e);
            exp_we[n+1]   = lw;
            exp_addr[n+1] = la;
            exp_wd[n+1]   = lwd;
            model_wd      = lwd;
        end
        if (e_if) begin
            e.due  = n + LAT;
            e.data = memf(ia);
            if_q.push_back(e);
            exp_we[n+1]   = 2'b00;
            exp_addr[n+1] = ia;
            exp_wd[n+1]   = model_wd;
        end
        if (e_if || e_ls) begin
            last_grant = n;
            next_free  = n + LAT + 1;
        end
        if (r) begin
            if_q.delete();
            ls_q.delete();
            exp_we.delete();
            exp_addr.delete();
            exp_wd.delete();
            last_grant = -100;
            next_free  = n + 1;
            if_bypass  = 0;
            model_wd   = '0;
            last_if    = '0;
            last_ls    = '0;
        end
        if_acc = e_if;
        ls_acc = e_ls;
    endtask

    task automatic idleCycle();
        logic ga;
        logic gb;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, ga, gb);
    endtask

    // Random requesters. A request is held until it is granted, or until it
    // is dropped at random.
    task automatic randomCycle(input int new_pct, input int drop_pct);
        logic ga;
        logic gb;
        if (!if_pend && $urandom_range(99) < new_pct) begin
            if_pend = 1'b1;
            if_a    = $urandom & 32'hFFFF_FFFC;
        end else if (if_pend && $urandom_range(99) < drop_pct) begin
            if_pend = 1'b0;
        end
        if (!ls_pend && $urandom_range(99) < new_pct) begin
            ls_pend = 1'b1;
            ls_a    = $urandom;
            ls_d    = $urandom;
            ls_w    = 2'($urandom_range(3));
        end else if (ls_pend && $urandom_range(99) < drop_pct) begin
            ls_pend = 1'b0;
        end
        applyStimulus(1'b0, if_pend, if_a, ls_pend, ls_w, ls_a, ls_d, ga, gb);
        if (ga) if_pend = 1'b0;
        if (gb) ls_pend = 1'b0;
    endtask

    // Monitor. Each cycle it checks the memory-side registers, the busy flag
    // and the completion pulses against what the accepted requests imply.
    initial begin : monitor
        int   m;
        logic exp_rv;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                m = cycle;
                if (exp_we.exists(m)) begin
                    checkOutput("mem_we", {30'd0, mem_we}, {30'd0, exp_we[m]});
                    checkOutput("mem_addr", mem_addr, exp_addr[m]);
                    checkOutput("mem_wd", mem_wd, exp_wd[m]);
                    exp_we.delete(m);
                    exp_addr.delete(m);
                    exp_wd.delete(m);
                end else begin
                    checkOutput("mem_we_quiet", {30'd0, mem_we}, 32'd0);
                end
                checkOutput("busy", {31'd0, busy}, {31'd0, (m > last_grant) && (m <= last_grant + LAT)});

                exp_rv = (if_q.size() > 0) && (if_q[0].due == m);
                checkOutput("if_rvalid", {31'd0, if_rvalid}, {31'd0, exp_rv});
                if (exp_rv) begin
                    e = if_q.pop_front();
                    checkOutput("if_rdata", if_rdata, e.data);
                    last_if = e.data;
                end else begin
                    checkOutput("if_rdata_hold", if_rdata, last_if);
                end

                exp_rv = (ls_q.size() > 0) && (ls_q[0].due == m);
                checkOutput("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, exp_rv});
                if (exp_rv) begin
                    e = ls_q.pop_front();
                    checkOutput("ls_rdata", ls_rdata, e.data);
                    last_ls = e.data;
                end else begin
                    checkOutput("ls_rdata_hold", ls_rdata, last_ls);
                end
            end
        end
    end

    initial begin
        logic ga;
        logic gb;

        // Reset, then check the idle state.
        repeat (3) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, ga, gb);
        idleCycle();
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mem_we", {30'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wd", mem_wd, 32'd0);
        checkOutput("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        checkOutput("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
        mon_en = 1'b1;

        // Directed LS read and LS write.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b00, 32'h10, 32'd0, ga, gb);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b11, 32'h20, 32'h1234_5678, ga, gb);
        repeat (3) idleCycle();

        // Both requesters held continuously, to exercise the starvation limit.
        repeat (80) randomCycle(100, 0);

        // Mixed random traffic with dropped requests.
        repeat (800) randomCycle(40, 8);

        // Reset in the first cycle of an LS write; no completion must follow.
        if_pend = 1'b0;
        ls_pend = 1'b0;
        repeat (LAT + 2) idleCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b11, 32'h40, 32'hCAFE_F00D, ga, gb);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, ga, gb);
        repeat (4) idleCycle();

        // An IF request that pulses for one cycle while the port is busy is dropped.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b00, 32'h80, 32'd0, ga, gb);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 2'b00, 32'd0, 32'd0, ga, gb);
        repeat (4) idleCycle();

        // More random traffic after the reset, then drain.
        repeat (200) randomCycle(50, 5);
        if_pend = 1'b0;
        ls_pend = 1'b0;
        repeat (LAT + 3) idleCycle();
        checkOutput("if_q_drained", if_q.size(), 32'd0);
        checkOutput("ls_q_drained", ls_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
